// File: rtl/pic_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pic_exec_ctrl
//  Purpose  : PIC16F instruction-cycle controller. Sequences Q1..Q4, holds
//             the instruction register, decodes it into ALU controls and
//             register-file / W / PC / stack strobes, and squashes the
//             instruction fetched behind a taken skip or branch.
//  Revision : 1.0  initial release
// ============================================================================
module pic_exec_ctrl #(
    parameter int PC_W    = 11,
    parameter int FADDR_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic [13:0]        instr_i,
    input  logic               instr_valid_i,
    output logic               instr_ack_o,
    output logic [1:0]         q_phase_o,
    output logic [3:0]         alu_op_o,
    output logic               alu_d_o,
    output logic               alu_status_wr_en_o,
    output logic [2:0]         alu_b_in_o,
    output logic               alu_lit_sel_o,
    output logic [7:0]         lit_o,
    output logic [FADDR_W-1:0] f_addr_o,
    input  logic               alu_z_i,
    input  logic               alu_bit_test_res_i,
    output logic               rf_rd_en_o,
    output logic               rf_wr_en_o,
    output logic               w_wr_en_o,
    output logic               pc_load_o,
    output logic               pc_from_stack_o,
    output logic [PC_W-1:0]    pc_target_o,
    output logic               stack_push_o,
    output logic               stack_pop_o,
    output logic               illegal_o
);

    // ALU operation codes shared with the ALU
    localparam logic [3:0] OP_ZERO   = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_IOR    = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_COM    = 4'd6;
    localparam logic [3:0] OP_DEC    = 4'd7;
    localparam logic [3:0] OP_INC    = 4'd8;
    localparam logic [3:0] OP_PASSLF = 4'd9;
    localparam logic [3:0] OP_PASSW  = 4'd10;
    localparam logic [3:0] OP_RLF    = 4'd11;
    localparam logic [3:0] OP_RRF    = 4'd12;
    localparam logic [3:0] OP_SWAP   = 4'd13;
    localparam logic [3:0] OP_BC     = 4'd14;
    localparam logic [3:0] OP_BS     = 4'd15;

    localparam logic [13:0] INSTR_NOP = 14'h0000;

    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_t;

    phase_t      phase_q;
    logic [13:0] ir_q;
    logic        squash_q;   // current IR is a NOP standing in for a squashed fetch
    logic        squash_d;

    // decode results
    logic [3:0] dec_op;
    logic       dec_d, dec_lit, dec_rd, dec_wf, dec_ww, dec_st;
    logic       dec_pcl, dec_fstk, dec_push, dec_pop, dec_ill;
    logic       dec_skip_z, dec_skip_bt, dec_branch;

    // Phase sequencing and IR load; async reset drops any pending Q4 at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= Q1;
            ir_q     <= INSTR_NOP;
            squash_q <= 1'b0;
        end else if (run_i) begin
            case (phase_q)
                Q1:      phase_q <= Q2;
                Q2:      phase_q <= Q3;
                Q3:      phase_q <= Q4;
                default: phase_q <= Q1;
            endcase
            if (phase_q == Q4) begin
                ir_q     <= (squash_d || !instr_valid_i) ? INSTR_NOP : instr_i;
                squash_q <= squash_d;
            end
        end
    end

    // Instruction decode, purely from the IR so it is stable for all phases
    always_comb begin
        dec_op      = OP_ZERO;
        dec_d       = 1'b0;
        dec_lit     = 1'b0;
        dec_rd      = 1'b0;
        dec_wf      = 1'b0;
        dec_ww      = 1'b0;
        dec_st      = 1'b0;
        dec_pcl     = 1'b0;
        dec_fstk    = 1'b0;
        dec_push    = 1'b0;
        dec_pop     = 1'b0;
        dec_ill     = 1'b0;
        dec_skip_z  = 1'b0;
        dec_skip_bt = 1'b0;
        dec_branch  = 1'b0;
        case (ir_q[13:12])
            2'b00: begin
                dec_d = ir_q[7];
                case (ir_q[11:8])
                    4'h0: begin
                        if (ir_q[7]) begin                 // MOVWF
                            dec_op = OP_PASSW;
                            dec_wf = 1'b1;
                        end else if (ir_q[6:0] == 7'h08) begin  // RETURN
                            dec_pcl    = 1'b1;
                            dec_fstk   = 1'b1;
                            dec_pop    = 1'b1;
                            dec_branch = 1'b1;
                        end else if (ir_q[4:0] != 5'd0) begin   // not a NOP form
                            dec_ill = 1'b1;
                        end
                    end
                    4'h1: begin                            // CLRF / CLRW
                        dec_st = 1'b1;
                        dec_wf = ir_q[7];
                        dec_ww = !ir_q[7];
                    end
                    default: begin                         // f-operand byte ops
                        dec_rd = 1'b1;
                        dec_wf = ir_q[7];
                        dec_ww = !ir_q[7];
                        dec_st = 1'b1;
                        case (ir_q[11:8])
                            4'h2:    dec_op = OP_SUB;
                            4'h3:    dec_op = OP_DEC;
                            4'h4:    dec_op = OP_IOR;
                            4'h5:    dec_op = OP_AND;
                            4'h6:    dec_op = OP_XOR;
                            4'h7:    dec_op = OP_ADD;
                            4'h8:    dec_op = OP_PASSLF;
                            4'h9:    dec_op = OP_COM;
                            4'hA:    dec_op = OP_INC;
                            4'hB: begin dec_op = OP_DEC; dec_st = 1'b0; dec_skip_z = 1'b1; end
                            4'hC:    dec_op = OP_RRF;
                            4'hD:    dec_op = OP_RLF;
                            4'hE: begin dec_op = OP_SWAP; dec_st = 1'b0; end
                            default: begin dec_op = OP_INC; dec_st = 1'b0; dec_skip_z = 1'b1; end
                        endcase
                    end
                endcase
            end
            2'b01: begin                                   // bit ops
                dec_rd = 1'b1;
                dec_op = ir_q[10] ? OP_BS : OP_BC;
                if (!ir_q[11]) begin
                    dec_d  = 1'b1;
                    dec_wf = 1'b1;
                end else begin
                    dec_skip_bt = 1'b1;
                end
            end
            2'b10: begin                                   // CALL / GOTO
                dec_pcl    = 1'b1;
                dec_push   = !ir_q[11];
                dec_branch = 1'b1;
            end
            default: begin                                 // literal ops
                dec_lit = 1'b1;
                dec_ww  = 1'b1;
                case (ir_q[11:10])
                    2'b00: dec_op = OP_PASSLF;             // MOVLW
                    2'b01: begin                           // RETLW
                        dec_op     = OP_PASSLF;
                        dec_pcl    = 1'b1;
                        dec_fstk   = 1'b1;
                        dec_pop    = 1'b1;
                        dec_branch = 1'b1;
                    end
                    2'b10: begin
                        dec_st = 1'b1;
                        case (ir_q[9:8])
                            2'b00: dec_op = OP_IOR;
                            2'b01: dec_op = OP_AND;
                            2'b10: dec_op = OP_XOR;
                            default: begin                 // 0x3Bxx is undefined
                                dec_lit = 1'b0;
                                dec_ww  = 1'b0;
                                dec_st  = 1'b0;
                                dec_ill = 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        dec_st = 1'b1;
                        dec_op = ir_q[9] ? OP_ADD : OP_SUB;  // SUBLW is lit - W
                    end
                endcase
            end
        endcase
    end

    // Skip/branch decision for the instruction finishing this Q4
    always_comb begin
        squash_d = !squash_q && (dec_branch ||
                                 (dec_skip_z  && alu_z_i) ||
                                 (dec_skip_bt && alu_bit_test_res_i));
    end

    logic w_q2_en;
    logic w_q4_en;
    assign w_q2_en = run_i && (phase_q == Q2) && !squash_q;
    assign w_q4_en = run_i && (phase_q == Q4) && !squash_q;

    assign instr_ack_o        = run_i && (phase_q == Q4);
    assign q_phase_o          = phase_q;
    assign alu_op_o           = dec_op;
    assign alu_d_o            = dec_d;
    assign alu_lit_sel_o      = dec_lit;
    assign alu_b_in_o         = ir_q[9:7];
    assign lit_o              = ir_q[7:0];
    assign f_addr_o           = ir_q[FADDR_W-1:0];
    assign pc_target_o        = ir_q[PC_W-1:0];
    assign rf_rd_en_o         = w_q2_en && dec_rd;
    assign rf_wr_en_o         = w_q4_en && dec_wf;
    assign w_wr_en_o          = w_q4_en && dec_ww;
    assign alu_status_wr_en_o = w_q4_en && dec_st;
    assign pc_load_o          = w_q4_en && dec_pcl;
    assign pc_from_stack_o    = w_q4_en && dec_fstk;
    assign stack_push_o       = w_q4_en && dec_push;
    assign stack_pop_o        = w_q4_en && dec_pop;
    assign illegal_o          = w_q4_en && dec_ill;

endmodule
`default_nettype wire

// File: tb/tb_pic_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pic_exec_ctrl
//  Purpose  : Self-checking bench for pic_exec_ctrl against an opcode-table
//             model of the PIC16F instruction set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pic_exec_ctrl;

    localparam logic [3:0] ZERO = 4'd0, ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3,
                           IOR = 4'd4, XOR_ = 4'd5, COM = 4'd6, DEC = 4'd7,
                           INC = 4'd8, PLF = 4'd9, PW = 4'd10, RLF = 4'd11,
                           RRF = 4'd12, SWP = 4'd13, BC = 4'd14, BS = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, run, instr_valid, alu_z, bt;
    logic [13:0] instr;
    logic        ack, d, st, lsel, rd, wf, ww, pcl, fstk, push, pop, ill;
    logic [1:0]  q_phase;
    logic [3:0]  op;
    logic [2:0]  b_in;
    logic [7:0]  lit;
    logic [6:0]  f_addr;
    logic [10:0] pct;

    pic_exec_ctrl #(.PC_W(11), .FADDR_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run), .instr_i(instr),
        .instr_valid_i(instr_valid), .instr_ack_o(ack), .q_phase_o(q_phase),
        .alu_op_o(op), .alu_d_o(d), .alu_status_wr_en_o(st), .alu_b_in_o(b_in),
        .alu_lit_sel_o(lsel), .lit_o(lit), .f_addr_o(f_addr), .alu_z_i(alu_z),
        .alu_bit_test_res_i(bt), .rf_rd_en_o(rd), .rf_wr_en_o(wf),
        .w_wr_en_o(ww), .pc_load_o(pcl), .pc_from_stack_o(fstk),
        .pc_target_o(pct), .stack_push_o(push), .stack_pop_o(pop),
        .illegal_o(ill)
    );

    // Opcode table: dmode 0=0,1=1,2=IR[7]; wmode 0 none,1 f,2 W,3 by d;
    // skip 0 none,1 on Z,2 on bit test,3 always (branch)
    typedef struct {
        logic [13:0] mask, match;
        logic [3:0]  op;
        int dmode, lit, rd, wmode, st, pcl, fstk, push, pop, skip;
    } ent_t;
    ent_t tbl[$];

    typedef struct {
        logic [3:0] op;
        bit d, lit, rd, wf, ww, st, pcl, fstk, push, pop, ill;
        int skip;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] lit;
        logic [2:0] b;
        logic [10:0] pct;
        logic rd, wf, ww, st, pcl, fstk, push, pop, ill, ack, lsel;
    } snap_t;
    snap_t snaps[4];

    int n_tests = 0;
    int n_fail  = 0;
    int          m_ph;
    logic [13:0] m_ir;

    task automatic add(input logic [13:0] m, input logic [13:0] mt, input logic [3:0] o,
                       input int dm, input int li, input int r, input int wm, input int s,
                       input int pl, input int fs, input int pu, input int po, input int sk);
        ent_t e;
        e.mask = m; e.match = mt; e.op = o; e.dmode = dm; e.lit = li; e.rd = r;
        e.wmode = wm; e.st = s; e.pcl = pl; e.fstk = fs; e.push = pu; e.pop = po;
        e.skip = sk;
        tbl.push_back(e);
    endtask

    function automatic exp_t lookup(input logic [13:0] ir);
        exp_t r;
        bit   found = 0;
        r.op = ZERO; r.d = 0; r.lit = 0; r.rd = 0; r.wf = 0; r.ww = 0; r.st = 0;
        r.pcl = 0; r.fstk = 0; r.push = 0; r.pop = 0; r.ill = 0; r.skip = 0;
        foreach (tbl[i]) begin
            if (!found && ((ir & tbl[i].mask) == tbl[i].match)) begin
                found  = 1;
                r.op   = tbl[i].op;
                r.d    = (tbl[i].dmode == 2) ? ir[7] : (tbl[i].dmode == 1);
                r.lit  = tbl[i].lit != 0;
                r.rd   = tbl[i].rd != 0;
                r.wf   = (tbl[i].wmode == 1) || (tbl[i].wmode == 3 && ir[7]);
                r.ww   = (tbl[i].wmode == 2) || (tbl[i].wmode == 3 && !ir[7]);
                r.st   = tbl[i].st != 0;
                r.pcl  = tbl[i].pcl != 0;
                r.fstk = tbl[i].fstk != 0;
                r.push = tbl[i].push != 0;
                r.pop  = tbl[i].pop != 0;
                r.skip = tbl[i].skip;
            end
        end
        if (!found) r.ill = 1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit takes_skip(input exp_t e);
        return (e.skip == 3) || (e.skip == 1 && alu_z) || (e.skip == 2 && bt);
    endfunction

    task automatic check_all();
        exp_t e;
        bit   q4, q2;
        e  = lookup(m_ir);
        q4 = run && (m_ph == 3);
        q2 = run && (m_ph == 1);
        chk("q_phase", 16'(q_phase), 16'(m_ph));
        chk("instr_ack", 16'(ack), 16'(q4));
        chk("alu_op", 16'(op), 16'(e.op));
        chk("alu_d", 16'(d), 16'(e.d));
        chk("alu_b_in", 16'(b_in), 16'(m_ir[9:7]));
        chk("lit_sel", 16'(lsel), 16'(e.lit));
        chk("lit", 16'(lit), 16'(m_ir[7:0]));
        chk("f_addr", 16'(f_addr), 16'(m_ir[6:0]));
        chk("pc_target", 16'(pct), 16'(m_ir[10:0]));
        chk("rf_rd_en", 16'(rd), 16'(q2 && e.rd));
        chk("rf_wr_en", 16'(wf), 16'(q4 && e.wf));
        chk("w_wr_en", 16'(ww), 16'(q4 && e.ww));
        chk("status_wr_en", 16'(st), 16'(q4 && e.st));
        chk("pc_load", 16'(pcl), 16'(q4 && e.pcl));
        chk("pc_from_stack", 16'(fstk), 16'(q4 && e.fstk));
        chk("stack_push", 16'(push), 16'(q4 && e.push));
        chk("stack_pop", 16'(pop), 16'(q4 && e.pop));
        chk("illegal", 16'(ill), 16'(q4 && e.ill));
        snaps[m_ph].op = op;   snaps[m_ph].lit = lit; snaps[m_ph].b = b_in;
        snaps[m_ph].pct = pct; snaps[m_ph].rd = rd;   snaps[m_ph].wf = wf;
        snaps[m_ph].ww = ww;   snaps[m_ph].st = st;   snaps[m_ph].pcl = pcl;
        snaps[m_ph].fstk = fstk; snaps[m_ph].push = push; snaps[m_ph].pop = pop;
        snaps[m_ph].ill = ill; snaps[m_ph].ack = ack; snaps[m_ph].lsel = lsel;
    endtask

    // One clock: check at the current state, then advance the model at the edge
    task automatic cyc();
        int          nph;
        logic [13:0] nir;
        #1;
        check_all();
        nph = m_ph;
        nir = m_ir;
        if (rst_n && run) begin
            if (m_ph == 3) nir = (takes_skip(lookup(m_ir)) || !instr_valid) ? 14'h0 : instr;
            nph = (m_ph + 1) % 4;
        end
        @(posedge clk);
        m_ph = nph;
        m_ir = nir;
        #1;
    endtask

    task automatic exec4(input logic [13:0] nxt, input bit v, input bit z, input bit b);
        for (int i = 0; i < 4; i++) begin
            run = 1; instr = nxt; instr_valid = v; alu_z = z; bt = b;
            cyc();
        end
    endtask

    task automatic hit_reset();
        rst_n = 0;
        m_ph  = 0;
        m_ir  = 14'h0;
    endtask

    logic [13:0] picks [12] = '{14'h0787, 14'h0BA1, 14'h0F21, 14'h1DA0, 14'h19A0,
                                14'h2123, 14'h2A55, 14'h0008, 14'h3455, 14'h3055,
                                14'h3B00, 14'h0001};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add(14'h3F9F, 14'h0000, ZERO, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); // NOP
        add(14'h3FFF, 14'h0008, ZERO, 2, 0, 0, 0, 0, 1, 1, 0, 1, 3); // RETURN
        add(14'h3F80, 14'h0080, PW,   2, 0, 0, 1, 0, 0, 0, 0, 0, 0); // MOVWF
        add(14'h3F80, 14'h0180, ZERO, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0); // CLRF
        add(14'h3F80, 14'h0100, ZERO, 2, 0, 0, 2, 1, 0, 0, 0, 0, 0); // CLRW
        add(14'h3F00, 14'h0200, SUB,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // SUBWF
        add(14'h3F00, 14'h0300, DEC,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // DECF
        add(14'h3F00, 14'h0400, IOR,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // IORWF
        add(14'h3F00, 14'h0500, AND_, 2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // ANDWF
        add(14'h3F00, 14'h0600, XOR_, 2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // XORWF
        add(14'h3F00, 14'h0700, ADD,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // ADDWF
        add(14'h3F00, 14'h0800, PLF,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // MOVF
        add(14'h3F00, 14'h0900, COM,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // COMF
        add(14'h3F00, 14'h0A00, INC,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // INCF
        add(14'h3F00, 14'h0B00, DEC,  2, 0, 1, 3, 0, 0, 0, 0, 0, 1); // DECFSZ
        add(14'h3F00, 14'h0C00, RRF,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // RRF
        add(14'h3F00, 14'h0D00, RLF,  2, 0, 1, 3, 1, 0, 0, 0, 0, 0); // RLF
        add(14'h3F00, 14'h0E00, SWP,  2, 0, 1, 3, 0, 0, 0, 0, 0, 0); // SWAPF
        add(14'h3F00, 14'h0F00, INC,  2, 0, 1, 3, 0, 0, 0, 0, 0, 1); // INCFSZ
        add(14'h3C00, 14'h1000, BC,   1, 0, 1, 1, 0, 0, 0, 0, 0, 0); // BCF
        add(14'h3C00, 14'h1400, BS,   1, 0, 1, 1, 0, 0, 0, 0, 0, 0); // BSF
        add(14'h3C00, 14'h1800, BC,   0, 0, 1, 0, 0, 0, 0, 0, 0, 2); // BTFSC
        add(14'h3C00, 14'h1C00, BS,   0, 0, 1, 0, 0, 0, 0, 0, 0, 2); // BTFSS
        add(14'h3800, 14'h2000, ZERO, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3); // CALL
        add(14'h3800, 14'h2800, ZERO, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3); // GOTO
        add(14'h3C00, 14'h3000, PLF,  0, 1, 0, 2, 0, 0, 0, 0, 0, 0); // MOVLW
        add(14'h3C00, 14'h3400, PLF,  0, 1, 0, 2, 0, 1, 1, 0, 1, 3); // RETLW
        add(14'h3F00, 14'h3800, IOR,  0, 1, 0, 2, 1, 0, 0, 0, 0, 0); // IORLW
        add(14'h3F00, 14'h3900, AND_, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0); // ANDLW
        add(14'h3F00, 14'h3A00, XOR_, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0); // XORLW
        add(14'h3E00, 14'h3C00, SUB,  0, 1, 0, 2, 1, 0, 0, 0, 0, 0); // SUBLW
        add(14'h3E00, 14'h3E00, ADD,  0, 1, 0, 2, 1, 0, 0, 0, 0, 0); // ADDLW

        run = 0; instr = 14'h0; instr_valid = 0; alu_z = 0; bt = 0;
        hit_reset();
        #1;
        chk("reset_phase", 16'(q_phase), 16'd0);
        chk("reset_op", 16'(op), 16'(ZERO));
        chk("reset_ack", 16'(ack), 16'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;

        // ADDWF 0x07,f
        exec4(14'h0787, 1, 0, 0);
        exec4(14'h0BA1, 1, 0, 0);
        chk("t1_rd_q2", 16'(snaps[1].rd), 16'd1);
        chk("t1_rd_q1", 16'(snaps[0].rd), 16'd0);
        chk("t1_wf_q4", 16'(snaps[3].wf), 16'd1);
        chk("t1_ww_q4", 16'(snaps[3].ww), 16'd0);
        chk("t1_st_q4", 16'(snaps[3].st), 16'd1);
        chk("t1_op", 16'(snaps[3].op), 16'(ADD));

        // DECFSZ with Z set: following MOVLW is squashed
        exec4(14'h3055, 1, 1, 0);
        chk("t2_wf", 16'(snaps[3].wf), 16'd1);
        chk("t2_st", 16'(snaps[3].st), 16'd0);
        chk("t2_op", 16'(snaps[3].op), 16'(DEC));
        exec4(14'h0BA1, 1, 0, 0);
        chk("t2_squash_ww", 16'(snaps[3].ww), 16'd0);
        chk("t2_squash_lit", 16'(snaps[3].lit), 16'h00);
        chk("t2_squash_ack", 16'(snaps[3].ack), 16'd1);
        // DECFSZ with Z clear: MOVLW runs
        exec4(14'h3055, 1, 0, 0);
        exec4(14'h1DA0, 1, 0, 0);
        chk("t2_movlw_ww", 16'(snaps[3].ww), 16'd1);
        chk("t2_movlw_lit", 16'(snaps[3].lit), 16'h55);
        chk("t2_movlw_lsel", 16'(snaps[3].lsel), 16'd1);

        // BTFSS 0x20,3 with bit test true
        exec4(14'h3055, 1, 0, 1);
        chk("t3_b_in", 16'(snaps[3].b), 16'd3);
        chk("t3_rd", 16'(snaps[1].rd), 16'd1);
        chk("t3_wf", 16'(snaps[3].wf), 16'd0);
        chk("t3_ww", 16'(snaps[3].ww), 16'd0);
        exec4(14'h2123, 1, 0, 0);
        chk("t3_squash_ww", 16'(snaps[3].ww), 16'd0);

        // CALL 0x123 then RETURN
        exec4(14'h3FFF, 1, 0, 0);
        chk("t4_pcl", 16'(snaps[3].pcl), 16'd1);
        chk("t4_push", 16'(snaps[3].push), 16'd1);
        chk("t4_pct", 16'(snaps[3].pct), 16'h123);
        exec4(14'h0008, 1, 0, 0);
        chk("t4_squash_ww", 16'(snaps[3].ww), 16'd0);
        exec4(14'h3FFF, 1, 0, 0);
        chk("t4_ret_pcl", 16'(snaps[3].pcl), 16'd1);
        chk("t4_ret_fstk", 16'(snaps[3].fstk), 16'd1);
        chk("t4_ret_pop", 16'(snaps[3].pop), 16'd1);
        chk("t4_ret_push", 16'(snaps[3].push), 16'd0);
        exec4(14'h0787, 1, 0, 0);

        // Reset during Q3 of ADDWF
        run = 1; instr = 14'h0;
        cyc(); cyc();
        hit_reset();
        #1;
        chk("t5_phase", 16'(q_phase), 16'd0);
        chk("t5_op", 16'(op), 16'(ZERO));
        cyc();
        rst_n = 1;
        exec4(14'h0787, 1, 0, 0);
        chk("t5_nop_wf", 16'(snaps[3].wf), 16'd0);
        chk("t5_nop_op", 16'(snaps[3].op), 16'(ZERO));
        // Reset while Q4 write strobe is live
        run = 1; instr = 14'h0;
        cyc(); cyc(); cyc();
        #1;
        chk("t5_q4_before", 16'(wf), 16'd1);
        hit_reset();
        #1;
        chk("t5_q4_killed", 16'(wf), 16'd0);
        cyc();
        rst_n = 1;
        exec4(14'h0787, 1, 0, 0);

        // run low for 5 cycles in Q2, invalid fetch, then illegal opcode
        run = 1; instr = 14'h0; instr_valid = 1;
        cyc();
        run = 0;
        repeat (5) cyc();
        chk("t6_hold_phase", 16'(q_phase), 16'd1);
        chk("t6_hold_rd", 16'(snaps[1].rd), 16'd0);
        run = 1; instr = 14'h3A00; instr_valid = 0;
        cyc(); cyc(); cyc();
        chk("t6_addwf_wf", 16'(snaps[3].wf), 16'd1);
        chk("t6_nop_loaded", 16'(op), 16'(ZERO));
        exec4(14'h0001, 1, 0, 0);
        run = 1; instr = 14'h0; instr_valid = 1;
        cyc(); cyc(); cyc();
        run = 0;
        cyc(); cyc();
        chk("t6_frozen_q4_ill", 16'(snaps[3].ill), 16'd0);
        chk("t6_frozen_q4_ack", 16'(snaps[3].ack), 16'd0);
        run = 1;
        cyc();
        chk("t6_ill", 16'(snaps[3].ill), 16'd1);
        chk("t6_ill_wf", 16'(snaps[3].wf), 16'd0);
        chk("t6_ill_ww", 16'(snaps[3].ww), 16'd0);

        // Randomized traffic against the table model
        for (int i = 0; i < 800; i++) begin
            run         = ($urandom_range(0, 9) != 0);
            instr_valid = ($urandom_range(0, 7) != 0);
            alu_z       = 1'($urandom);
            bt          = 1'($urandom);
            if ($urandom_range(0, 1) == 0) instr = 14'($urandom);
            else                           instr = picks[$urandom_range(0, 11)];
            if ($urandom_range(0, 199) == 0) begin
                hit_reset();
                cyc();
                rst_n = 1;
            end else begin
                cyc();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
